// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight-loader state encoding and tile geometry.
package tpu_pkg;

  localparam int TILE_BYTES = 9;
  localparam int NUM_COLS   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PUSH_LO = 3'd3,
    PUSH_HI = 3'd4,
    DONE    = 3'd5
  } wload_state_t;

  // Byte count of a load: tiles * bytes-per-tile, kept to 12 bits.
  function automatic logic [11:0] load_bytes(input logic [11:0] tiles);
    return tiles * 12'(TILE_BYTES);
  endfunction

endpackage

// File: rtl/col_rr_pointer.sv
// Mod-3 round-robin column pointer with advance enable and one-hot decode.
module col_rr_pointer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] onehot
);
  import tpu_pkg::*;

  logic [1:0] ptr_r;

  // Pointer register: cleared at load start, steps 0->1->2->0 on each push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (clear) begin
      ptr_r <= 2'd0;
    end else if (advance) begin
      if (ptr_r == 2'(NUM_COLS - 1)) begin
        ptr_r <= 2'd0;
      end else begin
        ptr_r <= ptr_r + 2'd1;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // One-hot decode of the current column.
  always_comb begin
    onehot = 3'b000;
    case (ptr_r)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  end

endmodule

// File: rtl/weight_dma_loader.sv
// Weight DMA loader: fetches 16-bit words from weight DRAM and pushes the
// bytes round-robin into the three columns of the weight FIFO.
module weight_dma_loader #(
  parameter int ADDR_W      = 24,
  parameter int TILE_BYTES  = 9,
  parameter int MAX_TILES_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [MAX_TILES_W-1:0] num_tiles,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [15:0]            mem_rdata,
  input  logic                   fifo_full,
  output logic                   push_col0,
  output logic                   push_col1,
  output logic                   push_col2,
  output logic [7:0]             push_data,
  output logic                   busy,
  output logic                   done,
  output logic [11:0]            bytes_pushed
);
  import tpu_pkg::*;

  wload_state_t      state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [11:0]       total_r;
  logic [15:0]       word_r;
  logic [2:0]        col_onehot_s;
  logic              push_fire_s;
  logic              last_byte_s;
  logic              col_clear_s;
  logic [11:0]       total_s;

  assign mem_addr = addr_r;

  // Push decode, last-byte detect and load length for a new start.
  always_comb begin
    push_fire_s = 1'b0;
    col_clear_s = 1'b0;
    last_byte_s = ((bytes_pushed + 12'd1) == total_r);
    total_s     = load_bytes(12'(num_tiles));
    if ((state_r == PUSH_LO || state_r == PUSH_HI) && !fifo_full) begin
      push_fire_s = 1'b1;
    end else begin
      push_fire_s = 1'b0;
    end
    if (state_r == IDLE && start && (num_tiles != '0)) begin
      col_clear_s = 1'b1;
    end else begin
      col_clear_s = 1'b0;
    end
  end

  col_rr_pointer u_col_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear   (col_clear_s),
    .advance (push_fire_s),
    .onehot  (col_onehot_s)
  );

  // Loader FSM with registered request, push, busy and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      total_r      <= 12'd0;
      word_r       <= 16'd0;
      bytes_pushed <= 12'd0;
      mem_req      <= 1'b0;
      push_col0    <= 1'b0;
      push_col1    <= 1'b0;
      push_col2    <= 1'b0;
      push_data    <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      push_col0 <= 1'b0;
      push_col1 <= 1'b0;
      push_col2 <= 1'b0;
      push_data <= 8'd0;
      done      <= 1'b0;
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (num_tiles == '0) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              addr_r       <= base_addr & ~ADDR_W'(1);
              total_r      <= total_s;
              bytes_pushed <= 12'd0;
              mem_req      <= 1'b1;
              busy         <= 1'b1;
              state_r      <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            word_r  <= mem_rdata;
            state_r <= PUSH_LO;
          end
        end
        PUSH_LO, PUSH_HI: begin
          if (push_fire_s) begin
            push_col0    <= col_onehot_s[0];
            push_col1    <= col_onehot_s[1];
            push_col2    <= col_onehot_s[2];
            push_data    <= (state_r == PUSH_LO) ? word_r[7:0] : word_r[15:8];
            bytes_pushed <= bytes_pushed + 12'd1;
            if (last_byte_s) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else if (state_r == PUSH_LO) begin
              state_r <= PUSH_HI;
            end else begin
              // Odd trailing byte never reaches here: the low half ends the load.
              addr_r  <= addr_r + ADDR_W'(2);
              mem_req <= 1'b1;
              state_r <= REQ;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_dma_loader.md
Name: weight_dma_loader

Overview:
- Upstream feeder for the dual weight FIFO in the TPU datapath.
- On `start`, it fetches `num_tiles` 3x3 weight tiles (9 bytes each) from weight DRAM as 16-bit words.
- It unpacks each word into bytes and pushes them round-robin into columns 0/1/2 of the weight FIFO.
- It supplies the weight-busy and DMA busy/done status consumed by the controller.

Parameters:
- ADDR_W, 24, DRAM byte-address width.
- TILE_BYTES, 9, bytes per weight tile (3x3 int8).
- MAX_TILES_W, 8, width of the tile-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  1-cycle pulse: begin load; sampled only in IDLE
- base_addr  in  ADDR_W  DRAM byte address of first tile (bit 0 ignored, word aligned)
- num_tiles  in  MAX_TILES_W  tiles to load
- mem_req  out  1  read request, held until mem_gnt
- mem_addr  out  ADDR_W  word-aligned byte address of request
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  16  read word; byte0=[7:0], byte1=[15:8]
- fifo_full  in  1  weight FIFO cannot accept a push this cycle
- push_col0/push_col1/push_col2  out  1  one-hot FIFO push strobe
- push_data  out  8  byte being pushed
- busy  out  1  load in progress (drives wt_busy/dma_busy)
- done  out  1  1-cycle pulse on completion (drives dma_done)
- bytes_pushed  out  12  running count of bytes pushed in current load

Behaviour:
- Reset: all outputs 0, state IDLE. Counters, address and column pointer are cleared. Reset asserted mid-load abandons the transfer immediately; a late mem_rvalid is ignored.
- Length: total = num_tiles*TILE_BYTES, computed as a 12-bit value (max 255*9 = 2295). words = ceil(total/2).
- The odd trailing byte of the last word (when total is odd) is discarded and never pushed.
- States:
  - IDLE: busy=0. On start with num_tiles=0: go to DONE, no memory traffic. On start with num_tiles>0: latch base_addr (bit0 cleared) and total, clear bytes_pushed and col_ptr=0, then go to REQ.
  - REQ: mem_req=1, mem_addr=current address. On mem_gnt go to WAIT. mem_req drops in the cycle after the grant.
  - WAIT: on mem_rvalid capture mem_rdata into a word register, then go to PUSH_LO. Exactly one outstanding read at a time.
  - PUSH_LO: if !fifo_full, assert push_col[col_ptr] with push_data=word[7:0], increment bytes_pushed, and advance col_ptr 0->1->2->0. Then:
    - if bytes_pushed+1 == total, go to DONE;
    - else go to PUSH_HI.
  - PUSH_LO stall: if fifo_full, hold the state with no push.
  - PUSH_HI: same push rule using word[15:8]. Then:
    - if bytes_pushed+1 == total, go to DONE;
    - else add 2 to the address (wraps modulo 2^ADDR_W) and go to REQ.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in REQ, WAIT, PUSH_LO and PUSH_HI.
- Push strobes are registered outputs. At most one push_colN is high per cycle, and push_data is valid only while a strobe is high.
- A start pulse while busy or in DONE is ignored.
- col_ptr is not reset between tiles: a tile's 9 bytes fill three bytes per column. Byte k of the load goes to column k mod 3.
- mem_rvalid outside WAIT is ignored.
- Latency:
  - start to first mem_req: 1 cycle.
  - mem_rvalid to first push: 1 cycle.
  - Unstalled throughput: 2 bytes per (grant latency + read latency + 2) cycles.

Decomposition:
- Shared package `tpu_pkg` holds:
  - the loader state enum `wload_state_t` (IDLE, REQ, WAIT, PUSH_LO, PUSH_HI, DONE);
  - the constant TILE_BYTES=9;
  - the constant NUM_COLS=3.
- One natural sub-module: `col_rr_pointer`, a mod-3 round-robin counter with advance enable and one-hot decode.
- The rest is a single FSM plus datapath.

Test Plan:
- base_addr=0x000100, num_tiles=1, memory returns 0x0201,0x0403,0x0605,0x0807,0x0009, zero-latency grant and rvalid. Required:
  - requests to 0x100, 0x102, 0x104, 0x106, 0x108;
  - bytes 01..09 pushed to columns 0,1,2,0,1,2,0,1,2;
  - byte 0x00 discarded;
  - one done pulse;
  - bytes_pushed=9.
- num_tiles=2, mem_gnt delayed 3 cycles each request. Required:
  - mem_req held high until grant, address stable while held;
  - 9 reads issued, 18 pushes;
  - done after the 18th push; busy low after done.
- fifo_full held high for 5 cycles during PUSH_HI of word 2. Required:
  - no push while full;
  - the same byte is pushed once fifo_full drops;
  - no byte is lost or duplicated; total pushes still 9.
- num_tiles=0 start. Required:
  - no mem_req;
  - done pulse 1 cycle after start;
  - busy never asserts.
- base_addr=0xFFFFFE, num_tiles=1. Required: address sequence 0xFFFFFE, 0x000000, 0x000002, and so on (wrap-around).
- Two scenarios on the same load:
  - Reset asserted in WAIT, then mem_rvalid pulsed after release. Required: all outputs 0, no push, no done.
  - A second start pulse during busy. Required: it is ignored and the first load completes normally.
